// File: rtl/logic_op_pkg.sv
// Shared opcode encodings, legality test and sequencer state type for the
// logical-unit requester.
package logic_op_pkg;

    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_NOT  = 3'b111;
    localparam logic [2:0] OP_NAND = 3'b000;
    localparam logic [2:0] OP_NOR  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // 011 and 100 have no result bus on the unit.
    function automatic logic op_legal(input logic [2:0] op);
        return (op != 3'b011) && (op != 3'b100);
    endfunction

endpackage

// File: rtl/logic_result_sel.sv
// Picks the one logical-unit output bus that belongs to the current opcode;
// every other bus is floating and must not leak into the result.
module logic_result_sel
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] res_and,
    input  logic [WIDTH-1:0] res_or,
    input  logic [WIDTH-1:0] res_not,
    input  logic [WIDTH-1:0] res_nand,
    input  logic [WIDTH-1:0] res_nor,
    input  logic [WIDTH-1:0] res_xor,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        // NOTE: default assigned before the case so every path drives result and no latch is inferred.
        result = '0;
        case (op)
            OP_AND:  result = res_and;
            OP_OR:   result = res_or;
            OP_NOT:  result = res_not;
            OP_NAND: result = res_nand;
            OP_NOR:  result = res_nor;
            OP_XOR:  result = res_xor;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/logic_op_issuer.sv
// Requester-side sequencer: accepts an op, enables the logical unit for SETTLE
// cycles, captures the matching result bus and returns it on a valid/ready port.
module logic_op_issuer
    import logic_op_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [WIDTH-1:0] lu_a,
    output logic [WIDTH-1:0] lu_b,
    output logic [2:0]       lu_p,
    output logic             lu_el,
    input  logic [WIDTH-1:0] lu_A,
    input  logic [WIDTH-1:0] lu_B,
    input  logic [WIDTH-1:0] lu_C,
    input  logic [WIDTH-1:0] lu_D,
    input  logic [WIDTH-1:0] lu_E,
    input  logic [WIDTH-1:0] lu_F,
    output logic [15:0]      op_count
);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       settle_cnt;
    logic [WIDTH-1:0] sel_result;

    logic_result_sel #(.WIDTH(WIDTH)) u_sel (
        .op      (lu_p),
        .res_and (lu_A),
        .res_or  (lu_B),
        .res_not (lu_C),
        .res_nand(lu_D),
        .res_nor (lu_E),
        .res_xor (lu_F),
        .result  (sel_result)
    );

    // All handshake and enable outputs decode from the registered state only.
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign lu_el     = (state != DRIVE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = op_legal(req_op) ? DRIVE : RESP;
            DRIVE:   if (settle_cnt == '0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: synchronous reset lives inside the clocked block, and all state is updated with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            lu_a       <= '0;
            lu_b       <= '0;
            lu_p       <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (op_legal(req_op)) begin
                            lu_a       <= req_a;
                            lu_b       <= req_b;
                            lu_p       <= req_op;
                            settle_cnt <= 4'(SETTLE - 1);
                        end else begin
                            // Illegal ops never touch the unit; lu_* keep their old values.
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    if (settle_cnt == '0) begin
                        rsp_data <= sel_result;
                        rsp_err  <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready && !rsp_err) op_count <= op_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_op_issuer.sv
// Scoreboard bench: two issuers (SETTLE=1 and SETTLE=3) each driving a model of
// the logical unit; a negedge monitor pops expected responses and compares.
module tb_logic_op_issuer;

    logic       clk;
    logic       rst;
    logic       req_valid [2];
    logic       req_ready [2];
    logic [2:0] req_op    [2];
    logic [7:0] req_a     [2];
    logic [7:0] req_b     [2];
    logic       rsp_valid [2];
    logic       rsp_ready [2];
    logic [7:0] rsp_data  [2];
    logic       rsp_err   [2];
    logic [7:0] lu_a      [2];
    logic [7:0] lu_b      [2];
    logic [2:0] lu_p      [2];
    logic       lu_el     [2];
    logic [15:0] op_count [2];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit rand_ready = 1'b0;

    logic [8:0]  q0 [$];
    logic [8:0]  q1 [$];
    logic [15:0] model_cnt  [2];
    logic [8:0]  prev_rsp   [2];
    logic        prev_valid [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: {err, data} straight from the opcode table.
    function automatic logic [8:0] ref_rsp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b101:  return {1'b0, a & b};
            3'b110:  return {1'b0, a | b};
            3'b111:  return {1'b0, ~a};
            3'b000:  return {1'b0, ~(a & b)};
            3'b001:  return {1'b0, ~(a | b)};
            3'b010:  return {1'b0, a ^ b};
            default: return {1'b1, 8'h00};
        endcase
    endfunction

    // Which of the six unit output buses (A..F) an opcode drives; 6 = none.
    function automatic int unit_idx(input logic [2:0] op);
        case (op)
            3'b101:  return 0;
            3'b110:  return 1;
            3'b111:  return 2;
            3'b000:  return 3;
            3'b001:  return 4;
            3'b010:  return 5;
            default: return 6;
        endcase
    endfunction

    function automatic void push_exp(input int k, input logic [8:0] v);
        if (k == 0) q0.push_back(v); else q1.push_back(v);
    endfunction

    function automatic int q_size(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [8:0] q_pop(input int k);
        return (k == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    function automatic void q_clear(input int k);
        if (k == 0) q0.delete(); else q1.delete();
    endfunction

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [7:0] junk [6];
        logic [7:0] res  [6];
        logic [7:0] bus  [6];

        always @(posedge clk) for (int i = 0; i < 6; i++) junk[i] <= 8'($urandom);

        // Only the enabled, opcode-selected bus carries a result; the rest carry junk.
        always_comb begin
            res[0] = lu_a[g] & lu_b[g];
            res[1] = lu_a[g] | lu_b[g];
            res[2] = ~lu_a[g];
            res[3] = ~(lu_a[g] & lu_b[g]);
            res[4] = ~(lu_a[g] | lu_b[g]);
            res[5] = lu_a[g] ^ lu_b[g];
            for (int i = 0; i < 6; i++) bus[i] = junk[i];
            if (!lu_el[g] && unit_idx(lu_p[g]) < 6) bus[unit_idx(lu_p[g])] = res[unit_idx(lu_p[g])];
        end

        logic_op_issuer #(.WIDTH(8), .SETTLE(g == 0 ? 1 : 3)) dut (
            .clk      (clk),
            .rst      (rst),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_op   (req_op[g]),
            .req_a    (req_a[g]),
            .req_b    (req_b[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_data (rsp_data[g]),
            .rsp_err  (rsp_err[g]),
            .lu_a     (lu_a[g]),
            .lu_b     (lu_b[g]),
            .lu_p     (lu_p[g]),
            .lu_el    (lu_el[g]),
            .lu_A     (bus[0]),
            .lu_B     (bus[1]),
            .lu_C     (bus[2]),
            .lu_D     (bus[3]),
            .lu_E     (bus[4]),
            .lu_F     (bus[5]),
            .op_count (op_count[g])
        );
    end

    // Monitor: compares every handshake against the scoreboard, tracks op_count.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                q_clear(k);
                model_cnt[k]  = '0;
                prev_valid[k] = 1'b0;
            end else begin
                check(op_count[k] == model_cnt[k], "op_count", op_count[k], model_cnt[k]);
                if (rsp_valid[k]) begin
                    check({req_ready[k], lu_el[k]} == 2'b01, "resp_ready_el", {req_ready[k], lu_el[k]}, 2'b01);
                    if (prev_valid[k])
                        check({rsp_err[k], rsp_data[k]} == prev_rsp[k], "rsp_stable", {rsp_err[k], rsp_data[k]}, prev_rsp[k]);
                    if (rsp_ready[k]) begin
                        check(q_size(k) != 0, "unexpected_rsp", q_size(k), 1);
                        if (q_size(k) != 0) begin
                            logic [8:0] e;
                            e = q_pop(k);
                            check({rsp_err[k], rsp_data[k]} == e, "rsp_err_data", {rsp_err[k], rsp_data[k]}, e);
                            if (!e[8]) model_cnt[k] = model_cnt[k] + 16'd1;
                        end
                        prev_valid[k] = 1'b0;
                    end else begin
                        prev_valid[k] = 1'b1;
                        prev_rsp[k]   = {rsp_err[k], rsp_data[k]};
                    end
                end else begin
                    prev_valid[k] = 1'b0;
                end
            end
        end
    end

    task automatic randomize_ready();
        if (rand_ready) begin
            rsp_ready[0] = 1'($urandom);
            rsp_ready[1] = 1'($urandom);
        end
    endtask

    // Presents a request from a drive point and returns at the drive point after the accepting edge.
    task automatic issue(input int k, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, output int acc);
        int t;
        t = 0;
        @(posedge clk); #1;
        randomize_ready();
        req_valid[k] = 1'b1;
        req_op[k]    = op;
        req_a[k]     = a;
        req_b[k]     = b;
        push_exp(k, ref_rsp(op, a, b));
        forever begin
            @(negedge clk);
            if (req_ready[k]) break;
            t++;
            if (t >= 200) begin
                $display("FAIL accept_timeout: inst %0d never ready", k);
                $fatal(1, "accept timeout");
            end
            @(posedge clk); #1;
            randomize_ready();
        end
        @(posedge clk); #1;
        acc = cyc;
        req_valid[k] = 1'b0;
        randomize_ready();
    endtask

    task automatic measure(input int k, input int exp_low);
        int lows;
        int t;
        lows = 0;
        t    = 0;
        while (t < 40) begin
            @(negedge clk);
            if (rsp_valid[k]) break;
            if (!lu_el[k]) lows++;
            t++;
        end
        check(rsp_valid[k] == 1'b1, "rsp_valid_seen", rsp_valid[k], 1);
        check(lows == exp_low, "lu_el_low_cycles", lows, exp_low);
        check(t == exp_low, "rsp_latency", t, exp_low);
    endtask

    task automatic wait_idle(input int k);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!req_ready[k] && t < 100);
        check(req_ready[k] == 1'b1, "return_to_idle", req_ready[k], 1);
    endtask

    initial begin
        int acc0;
        int acc1;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_op[k]    = 3'b000;
            req_a[k]     = 8'h00;
            req_b[k]     = 8'h00;
            rsp_ready[k] = 1'b1;
        end
        // A request held during reset must be ignored.
        req_valid[0] = 1'b1;
        req_op[0]    = 3'b101;
        req_a[0]     = 8'hFF;
        req_b[0]     = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid[0] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check(req_ready[k] == 1'b1, "reset_req_ready", req_ready[k], 1);
            check(rsp_valid[k] == 1'b0, "reset_rsp_valid", rsp_valid[k], 0);
            check({rsp_err[k], rsp_data[k]} == 9'h000, "reset_rsp", {rsp_err[k], rsp_data[k]}, 0);
            check({lu_p[k], lu_a[k], lu_b[k]} == 19'h0, "reset_lu_bus", {lu_p[k], lu_a[k], lu_b[k]}, 0);
            check(lu_el[k] == 1'b1, "reset_lu_el", lu_el[k], 1);
            check(op_count[k] == 16'h0000, "reset_op_count", op_count[k], 0);
        end

        // Reset in the second DRIVE cycle of the SETTLE=3 instance drops the op.
        issue(1, 3'b001, 8'h00, 8'h01, acc1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check(lu_el[1] == 1'b1, "midop_rst_lu_el", lu_el[1], 1);
        check(op_count[1] == 16'h0000, "midop_rst_op_count", op_count[1], 0);
        for (int i = 0; i < 6; i++) begin
            check(rsp_valid[1] == 1'b0, "midop_rst_no_rsp", rsp_valid[1], 0);
            @(negedge clk);
        end

        // AND on SETTLE=1.
        issue(0, 3'b101, 8'hF0, 8'h3C, acc0);
        measure(0, 1);
        wait_idle(0);
        check(op_count[0] == 16'd1, "and_op_count", op_count[0], 1);

        // Back-to-back NOT then XOR.
        issue(0, 3'b111, 8'h5A, 8'hFF, acc0);
        issue(0, 3'b010, 8'hAA, 8'h0F, acc1);
        check(acc1 - acc0 == 3, "throughput_spacing", acc1 - acc0, 3);
        wait_idle(0);

        // Illegal opcode: immediate error response, unit never enabled.
        issue(0, 3'b011, 8'h12, 8'h34, acc0);
        measure(0, 0);
        wait_idle(0);
        check(op_count[0] == 16'd3, "illegal_op_count", op_count[0], 3);

        // Backpressure for four cycles on an OR.
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        issue(0, 3'b110, 8'h0F, 8'h30, acc0);
        measure(0, 1);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            check(rsp_valid[0] == 1'b1, "bp_rsp_valid", rsp_valid[0], 1);
            check(rsp_data[0] == 8'h3F, "bp_rsp_data", rsp_data[0], 8'h3F);
            check(req_ready[0] == 1'b0, "bp_req_ready", req_ready[0], 0);
        end
        @(posedge clk); #1;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check(rsp_valid[0] == 1'b0, "bp_done", rsp_valid[0], 0);
        check(op_count[0] == 16'd4, "bp_op_count", op_count[0], 4);

        // NOR on SETTLE=3.
        issue(1, 3'b001, 8'h00, 8'h01, acc1);
        measure(1, 3);
        wait_idle(1);

        // op_count wrap from 0xFFFF.
        @(posedge clk); #1;
        force g_inst[0].dut.op_count = 16'hFFFF;
        model_cnt[0] = 16'hFFFF;
        @(negedge clk); #1;
        release g_inst[0].dut.op_count;
        issue(0, 3'b000, 8'h0F, 8'hFF, acc0);
        measure(0, 1);
        wait_idle(0);
        check(op_count[0] == 16'h0000, "op_count_wrap", op_count[0], 0);

        // Random traffic with random response backpressure on both instances.
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            int k;
            k = int'($urandom_range(0, 1));
            issue(k, 3'($urandom), 8'($urandom), 8'($urandom), acc0);
        end
        rand_ready = 1'b0;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b1;
        rsp_ready[1] = 1'b1;
        repeat (10) @(negedge clk);
        check(q0.size() == 0, "drain_q0", q0.size(), 0);
        check(q1.size() == 0, "drain_q1", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/logic_op_issuer.md
# logic_op_issuer

Requester-side sequencer for the 8-bit logical unit. It accepts operation requests over a valid/ready handshake and drives operands, opcode and the active-low enable into the logical unit. It then captures the single output bus that corresponds to the opcode and returns the result over a second valid/ready handshake. It sits between the decode stage and the logical unit, and is the only block that drives the unit's inputs.

## Interface
- WIDTH, 8: operand/result width.
- SETTLE, 1: cycles the unit is enabled before capture; legal range 1..15.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; equals (state==IDLE).
- req_op  in  3  opcode: 101 AND, 110 OR, 111 NOT (a only), 000 NAND, 001 NOR, 010 XOR; 011/100 illegal.
- req_a, req_b  in  WIDTH  operands.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  WIDTH  captured result; 0 on error.
- rsp_err  out  1  illegal opcode.
- lu_a, lu_b  out  WIDTH  operands to the unit.
- lu_p  out  3  opcode to the unit.
- lu_el  out  1  unit enable, active low.
- lu_A..lu_F  in  WIDTH  unit results: AND, OR, NOT, NAND, NOR, XOR.
- op_count  out  16  count of completed non-error responses; wraps.

## Operation
- States: IDLE, DRIVE, RESP.
- **IDLE:** req_ready=1 and lu_el=1.
  - On req_valid&&req_ready, latch op/a/b.
  - If op is legal, go to DRIVE and load the settle counter with SETTLE-1.
  - If op is illegal, set rsp_err=1 and rsp_data=0, then go to RESP. The unit is never enabled.
- **DRIVE:** lu_el=0, and lu_a/lu_b/lu_p come from the latched values.
  - The counter decrements each cycle.
  - When the counter reaches 0, register the bus selected by the opcode into rsp_data (AND→lu_A … XOR→lu_F) and set rsp_err=0. Then go to RESP.
  - Only the selected bus is sampled. The unselected buses are high-impedance and must never reach rsp_data.
- **RESP:** rsp_valid=1 and lu_el=1. rsp_data and rsp_err are held stable.
  - On rsp_ready, go to IDLE.
  - If rsp_err=0, op_count increments at that same edge (0xFFFF→0x0000).
- lu_a, lu_b and lu_p hold their last values outside DRIVE.
- There are no combinational paths from req_* or lu_* to rsp_*.

## Timing
- **Reset** (synchronous, applied on the edge where rst=1):
  - State goes to IDLE.
  - rsp_valid=0, rsp_err=0, rsp_data=0, lu_a=0, lu_b=0, lu_p=0, lu_el=1, op_count=0.
  - req_ready=1 from the first cycle after reset; a request is ignored while rst=1.
- **Reset mid-operation** (DRIVE or RESP): the transaction is dropped with no response and op_count is unchanged. lu_el returns to 1 the next cycle.
- **Legal op:** the request is accepted at edge N.
  - lu_el=0 for cycles N+1 .. N+SETTLE.
  - Capture happens at edge N+SETTLE+1.
  - rsp_valid=1 from cycle N+SETTLE+1.
- **Illegal op:** rsp_valid=1 from cycle N+1.
- **Throughput:** with rsp_ready held high, a new request is accepted every SETTLE+2 cycles.
- **Backpressure:** rsp_valid stays asserted and rsp_data stays unchanged for as long as rsp_ready=0. req_ready stays 0 throughout.
- **Simultaneous events:** rsp_ready and req_valid in the same RESP cycle do not overlap. The new request is accepted only once the block is back in IDLE.

## Structure
- Shared package logic_op_pkg holds:
  - the opcode localparams (OP_AND=3'b101, OP_OR=3'b110, OP_NOT=3'b111, OP_NAND=3'b000, OP_NOR=3'b001, OP_XOR=3'b010);
  - an op_legal function;
  - the state enum {IDLE, DRIVE, RESP}.
- One sub-module, logic_result_sel, is natural: a purely combinational mux from opcode and lu_A..lu_F to a single WIDTH result.
- The FSM, settle counter and op_count live in the top module.

## Test plan
- AND a=0xF0, b=0x3C, SETTLE=1 → lu_el low for exactly 1 cycle; rsp_data=0x30, rsp_err=0 at cycle N+2; op_count=1.
- NOT a=0x5A, b=0xFF, then XOR a=0xAA, b=0x0F, back-to-back with rsp_ready=1 → responses 0xA5 then 0xA5; the second request is accepted 3 cycles after the first.
- SETTLE=3, NOR a=0x00, b=0x01 → lu_el low for 3 cycles; rsp_data=0xFE at cycle N+4.
- Illegal op 011 → rsp_valid at N+1 with rsp_err=1 and rsp_data=0; lu_el never low; op_count unchanged.
- OR a=0x0F, b=0x30 with rsp_ready low for 4 cycles → rsp_valid and rsp_data=0x3F stable throughout; req_ready=0; handshake completes on the 5th cycle.
- rst pulsed in the second DRIVE cycle (SETTLE=3) → no rsp_valid, lu_el=1 next cycle, op_count unchanged. Preloading op_count to 0xFFFF and completing a legal op → op_count=0x0000.
